ex_mem: RTL and testbench

- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures EX results each cycle: GPR writeback info, plus HI/LO writeback info from MULT/MULTU/MTHI/MTLO.
- Presents the captured results to MEM on the next cycle.
- Supports pipeline stall (hold), bubble insertion when EX stalls but MEM proceeds, and flush on exception/redirect.
- Provides a valid flag and a saturating bubble counter for debug and performance.

---
 rtl/ex_mem.sv | 96 +++++++++
 tb/tb_ex_mem.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with stall, bubble, flush and bubble counter
module ex_mem #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic                  ex_write_reg_en,
  input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
  input  logic                  ex_write_hilo_en,
  input  logic [DATA_W-1:0]     ex_write_hi_data,
  input  logic [DATA_W-1:0]     ex_write_lo_data,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_result,
  output logic                  mem_write_reg_en,
  output logic [REG_ADDR_W-1:0] mem_write_reg_addr,
  output logic                  mem_write_hilo_en,
  output logic [DATA_W-1:0]     mem_write_hi_data,
  output logic [DATA_W-1:0]     mem_write_lo_data,
  output logic [CNT_W-1:0]      bubble_count
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_result;
  logic                  r_write_reg_en;
  logic [REG_ADDR_W-1:0] r_write_reg_addr;
  logic                  r_write_hilo_en;
  logic [DATA_W-1:0]     r_write_hi_data;
  logic [DATA_W-1:0]     r_write_lo_data;
  logic [CNT_W-1:0]      r_bubble_count;

  logic w_bubble;
  logic w_hold;
  logic w_count_bubble;
  logic w_cnt_sat;

  // Decode the per-cycle action; flush outranks both stall inputs
  always_comb begin
    w_bubble       = flush | (stall_ex & ~stall_mem);
    w_hold         = ~flush & stall_mem;
    w_count_bubble = ~flush & stall_ex & ~stall_mem;
    w_cnt_sat      = &r_bubble_count;
  end

  // Pipeline register: bubble clears control but keeps HI/LO data stable for forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid          <= 1'b0;
      r_result         <= '0;
      r_write_reg_en   <= 1'b0;
      r_write_reg_addr <= '0;
      r_write_hilo_en  <= 1'b0;
      r_write_hi_data  <= '0;
      r_write_lo_data  <= '0;
    end else if (w_bubble) begin
      r_valid          <= 1'b0;
      r_result         <= '0;
      r_write_reg_en   <= 1'b0;
      r_write_reg_addr <= '0;
      r_write_hilo_en  <= 1'b0;
    end else if (!w_hold) begin
      r_valid          <= ex_valid;
      r_result         <= ex_result;
      r_write_reg_en   <= ex_write_reg_en & ex_valid;
      r_write_reg_addr <= ex_write_reg_addr;
      r_write_hilo_en  <= ex_write_hilo_en & ex_valid;
      r_write_hi_data  <= ex_write_hi_data;
      r_write_lo_data  <= ex_write_lo_data;
    end
  end

  // Saturating count of stall bubbles; flush bubbles are not stall cost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_count <= '0;
    end else if (w_count_bubble && !w_cnt_sat) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign mem_valid          = r_valid;
  assign mem_result         = r_result;
  assign mem_write_reg_en   = r_write_reg_en;
  assign mem_write_reg_addr = r_write_reg_addr;
  assign mem_write_hilo_en  = r_write_hilo_en;
  assign mem_write_hi_data  = r_write_hi_data;
  assign mem_write_lo_data  = r_write_lo_data;
  assign bubble_count       = r_bubble_count;

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - directed self-checking bench for ex_mem
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst, stall_ex, stall_mem, flush;
  logic        ex_valid, ex_write_reg_en, ex_write_hilo_en;
  logic [31:0] ex_result, ex_write_hi_data, ex_write_lo_data;
  logic [4:0]  ex_write_reg_addr;

  logic        mem_valid, mem_write_reg_en, mem_write_hilo_en;
  logic [31:0] mem_result, mem_write_hi_data, mem_write_lo_data;
  logic [4:0]  mem_write_reg_addr;
  logic [15:0] bubble_count;

  logic        m4_valid, m4_write_reg_en, m4_write_hilo_en;
  logic [31:0] m4_result, m4_write_hi_data, m4_write_lo_data;
  logic [4:0]  m4_write_reg_addr;
  logic [3:0]  bubble_count4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_write_reg_en(ex_write_reg_en),
    .ex_write_reg_addr(ex_write_reg_addr), .ex_write_hilo_en(ex_write_hilo_en),
    .ex_write_hi_data(ex_write_hi_data), .ex_write_lo_data(ex_write_lo_data),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_write_reg_en(mem_write_reg_en),
    .mem_write_reg_addr(mem_write_reg_addr), .mem_write_hilo_en(mem_write_hilo_en),
    .mem_write_hi_data(mem_write_hi_data), .mem_write_lo_data(mem_write_lo_data),
    .bubble_count(bubble_count)
  );

  ex_mem #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_write_reg_en(ex_write_reg_en),
    .ex_write_reg_addr(ex_write_reg_addr), .ex_write_hilo_en(ex_write_hilo_en),
    .ex_write_hi_data(ex_write_hi_data), .ex_write_lo_data(ex_write_lo_data),
    .mem_valid(m4_valid), .mem_result(m4_result), .mem_write_reg_en(m4_write_reg_en),
    .mem_write_reg_addr(m4_write_reg_addr), .mem_write_hilo_en(m4_write_hilo_en),
    .mem_write_hi_data(m4_write_hi_data), .mem_write_lo_data(m4_write_lo_data),
    .bubble_count(bubble_count4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] res,
                         input logic ren, input logic [4:0] addr, input logic hen,
                         input logic [31:0] hi, input logic [31:0] lo, input logic [15:0] cnt);
    chk({tag, ".valid"},   mem_valid, v);
    chk({tag, ".result"},  mem_result, res);
    chk({tag, ".reg_en"},  mem_write_reg_en, ren);
    chk({tag, ".addr"},    mem_write_reg_addr, addr);
    chk({tag, ".hilo_en"}, mem_write_hilo_en, hen);
    chk({tag, ".hi"},      mem_write_hi_data, hi);
    chk({tag, ".lo"},      mem_write_lo_data, lo);
    chk({tag, ".count"},   bubble_count, cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] res, input logic ren,
                        input logic [4:0] addr, input logic hen,
                        input logic [31:0] hi, input logic [31:0] lo);
    ex_valid = v; ex_result = res; ex_write_reg_en = ren; ex_write_reg_addr = addr;
    ex_write_hilo_en = hen; ex_write_hi_data = hi; ex_write_lo_data = lo;
  endtask

  initial begin
    // reset with all inputs nonzero
    rst = 1'b1; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
    set_ex(1'b1, 32'hDEAD_BEEF, 1'b1, 5'd31, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    step(); step();
    chk_all("reset", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 16'd0);
    chk("reset.count4", bubble_count4, 4'd0);

    // plain load, one cycle after reset release
    rst = 1'b0;
    set_ex(1'b1, 32'h0000_1234, 1'b1, 5'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    chk_all("load1", 1'b1, 32'h0000_1234, 1'b1, 5'd5, 1'b1, 32'hFFFF_FFFF, 32'h1, 16'd0);

    // stall bubbles: EX stalled, MEM proceeding
    stall_ex = 1'b1;
    set_ex(1'b1, 32'h0000_ABCD, 1'b1, 5'd7, 1'b0, 32'h0000_0011, 32'h0000_0022);
    step();
    chk_all("bub1", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 16'd1);
    step();
    chk("bub2.count", bubble_count, 16'd2);
    step();
    chk_all("bub3", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 16'd3);
    chk("bub3.count4", bubble_count4, 4'd3);

    // release stall: new data loads next cycle
    stall_ex = 1'b0;
    step();
    chk_all("load2", 1'b1, 32'h0000_ABCD, 1'b1, 5'd7, 1'b0, 32'h11, 32'h22, 16'd3);

    // hold with both stalls while inputs wander
    stall_ex = 1'b1; stall_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ex(1'($urandom), $urandom, 1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
      step();
      chk_all("hold", 1'b1, 32'h0000_ABCD, 1'b1, 5'd7, 1'b0, 32'h11, 32'h22, 16'd3);
    end

    // illegal combination also holds
    stall_ex = 1'b0; stall_mem = 1'b1;
    set_ex(1'b1, 32'h0BAD_0BAD, 1'b1, 5'd3, 1'b1, 32'h99, 32'h88);
    step();
    chk_all("hold_illegal", 1'b1, 32'h0000_ABCD, 1'b1, 5'd7, 1'b0, 32'h11, 32'h22, 16'd3);

    // flush beats stall_ex: bubble but not counted
    flush = 1'b1; stall_ex = 1'b1; stall_mem = 1'b0;
    step();
    chk_all("flush_stall", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h11, 32'h22, 16'd3);

    // reload, then flush beats a full hold
    flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    set_ex(1'b1, 32'h0000_0777, 1'b1, 5'd12, 1'b1, 32'h0000_0033, 32'h0000_0044);
    step();
    chk_all("load3", 1'b1, 32'h777, 1'b1, 5'd12, 1'b1, 32'h33, 32'h44, 16'd3);
    flush = 1'b1; stall_ex = 1'b1; stall_mem = 1'b1;
    step();
    chk_all("flush_hold", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h33, 32'h44, 16'd3);

    // invalid instruction has its write enables sanitised
    flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    set_ex(1'b0, 32'h0000_0055, 1'b1, 5'd9, 1'b1, 32'h0000_0066, 32'h0000_0077);
    step();
    chk_all("sanitise", 1'b0, 32'h55, 1'b0, 5'd9, 1'b0, 32'h66, 32'h77, 16'd3);

    // 20 more stall bubbles: 16-bit counter reaches 23, 4-bit saturates at 15
    stall_ex = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat.count", bubble_count, 16'd23);
    chk("sat.count4", bubble_count4, 4'd15);
    chk("sat.hi4", m4_write_hi_data, 32'h66);
    step();
    chk("sat_stay.count", bubble_count, 16'd24);
    chk("sat_stay.count4", bubble_count4, 4'd15);

    // reset aborts a hold
    stall_mem = 1'b1; rst = 1'b1;
    step();
    chk_all("reset_hold", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 16'd0);
    chk("reset_hold.count4", bubble_count4, 4'd0);

    // first load after reset
    rst = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    set_ex(1'b1, 32'hCAFE_0001, 1'b0, 5'd1, 1'b1, 32'h1234_5678, 32'h8765_4321);
    step();
    chk_all("load4", 1'b1, 32'hCAFE_0001, 1'b0, 5'd1, 1'b1, 32'h1234_5678, 32'h8765_4321, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
